// File: rtl/multiport_regfile_ckpt.sv
// multiport_regfile_ckpt: NRD-read / NWR-write register file with priority write merge
// and a one-level shadow copy. The shadow is captured by ckpt_call and restored by restore_call.
// Latency: reads are combinational (0 cycles); writes, checkpoint and restore land on the next rising clk edge.
// Backpressure: none. Every call is accepted on every cycle.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   rd_addr / rd_data     NRD read ports, packed as port p at [p*AW +: AW] / [p*DW +: DW]
//   wr_call/addr/data     NWR write ports; the highest index wins on an address collision
//   ckpt_call             snapshot the post-write register state into the shadow copy
//   restore_call          copy the shadow back into the registers (needs a held checkpoint)
//   ckpt_valid            a checkpoint is currently held
//   restore_err           one-cycle pulse after a restore that found no checkpoint
//
// Build option: define RF_RD_BYPASS_EN to make reads return the same-cycle post-write-merge
// value. Restore is never bypassed. The default build reads registered state only.
module multiport_regfile_ckpt #(
  parameter int DW    = 8,
  parameter int NREGS = 4,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter logic [DW-1:0] RESET_VALUE = '0,
  localparam int AW   = (NREGS > 2) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  input  logic [NWR-1:0]    wr_call,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*DW-1:0] wr_data,
  input  logic              ckpt_call,
  input  logic              restore_call,
  output logic              ckpt_valid,
  output logic              restore_err
);

  logic [DW-1:0] regs   [NREGS];
  logic [DW-1:0] shadow [NREGS];
  logic [DW-1:0] nxt    [NREGS];
  logic [DW-1:0] rd_src [NREGS];

  logic restore_ok;
  logic restore_fail;

  assign restore_ok   = restore_call && ckpt_valid;
  assign restore_fail = restore_call && !ckpt_valid;

  // Apply the write ports in ascending order, so the highest-index port on an address wins.
  // Any address that no register decodes to falls through, so that write is dropped.
  // Writes are masked during reset, so a bypassed read still shows RESET_VALUE.
  always_comb begin
    for (int r = 0; r < NREGS; r++) nxt[r] = regs[r];
    for (int w = 0; w < NWR; w++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (!reset && wr_call[w] && (wr_addr[w*AW +: AW] == AW'(r)))
          nxt[r] = wr_data[w*DW +: DW];
      end
    end
  end

`ifdef RF_RD_BYPASS_EN
  assign rd_src = nxt;
`else
  assign rd_src = regs;
`endif

  // A read address that no register decodes to returns zero.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (rd_addr[p*AW +: AW] == AW'(r))
          rd_data[p*DW +: DW] = rd_src[r];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r]   <= RESET_VALUE;
        shadow[r] <= RESET_VALUE;
      end
      ckpt_valid  <= 1'b0;
      restore_err <= 1'b0;
    end else begin
      // A successful restore discards this cycle's writes.
      // A restore together with a checkpoint leaves the shadow untouched and keeps it armed.
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= restore_ok ? shadow[r] : nxt[r];
        if (ckpt_call && !restore_ok) shadow[r] <= nxt[r];
      end
      if (restore_ok)     ckpt_valid <= ckpt_call;
      else if (ckpt_call) ckpt_valid <= 1'b1;
      restore_err <= restore_fail;
    end
  end

endmodule

// File: tb/tb_multiport_regfile_ckpt.sv
// Self-checking bench for multiport_regfile_ckpt (DW=8, NREGS=4, NRD=2, NWR=2, RESET_VALUE=8'h5A).
// Expected read data is queued as stimulus is driven, then popped and compared when sampled.
// Build-dependent expectations follow RF_RD_BYPASS_EN.
module tb_multiport_regfile_ckpt;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic [1:0]  wr_call;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        ckpt_call;
  logic        restore_call;
  logic        ckpt_valid;
  logic        restore_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_v;

  multiport_regfile_ckpt #(
    .DW(8), .NREGS(4), .NRD(2), .NWR(2), .RESET_VALUE(8'h5A)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_call(wr_call), .wr_addr(wr_addr), .wr_data(wr_data),
    .ckpt_call(ckpt_call), .restore_call(restore_call),
    .ckpt_valid(ckpt_valid), .restore_err(restore_err)
  );

  always #5 clk = ~clk;

  // Stimulus-only helpers
  task automatic idle();
    wr_call = 2'b00; wr_addr = '0; wr_data = '0;
    ckpt_call = 1'b0; restore_call = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr1(input logic [1:0] a, input logic [7:0] d);
    wr_call = 2'b01; wr_addr = {2'd0, a}; wr_data = {8'h00, d};
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); rd_addr = 4'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    // A restore together with a checkpoint while none is held: error pulse, checkpoint taken.
    wr1(2'd0, 8'h11); ckpt_call = 1'b1; restore_call = 1'b1;
    exp_q.push_back(8'h11);
    tick(); idle(); rd_addr = 4'h0;
    #1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL pre_reset_r0 got %h want %h", rd_data[7:0], exp_v); end
    n_cmp++;
    if (ckpt_valid !== 1'b1) begin n_bad++; $display("FAIL both_noval_ckpt_valid got %b want 1", ckpt_valid); end
    n_cmp++;
    if (restore_err !== 1'b1) begin n_bad++; $display("FAIL both_noval_restore_err got %b want 1", restore_err); end
    // Assert reset mid-cycle: the effect must be immediate, without a clock edge.
    #2 reset = 1'b1;
    rd_addr = {2'd1, 2'd0};
    exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
    #1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL reset_r0 got %h want %h", rd_data[7:0], exp_v); end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[15:8] !== exp_v) begin n_bad++; $display("FAIL reset_r1 got %h want %h", rd_data[15:8], exp_v); end
    n_cmp++;
    if (ckpt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ckpt_valid got %b want 0", ckpt_valid); end
    n_cmp++;
    if (restore_err !== 1'b0) begin n_bad++; $display("FAIL reset_restore_err got %b want 0", restore_err); end
    rd_addr = {2'd3, 2'd2};
    exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
    #1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL reset_r2 got %h want %h", rd_data[7:0], exp_v); end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[15:8] !== exp_v) begin n_bad++; $display("FAIL reset_r3 got %h want %h", rd_data[15:8], exp_v); end
    tick(); reset = 1'b0;
  endtask

  task automatic test_write_priority();
    wr_call = 2'b11; wr_addr = {2'd2, 2'd2}; wr_data = {8'h22, 8'h11};
    exp_q.push_back(8'h22);
    tick(); idle(); rd_addr = {2'd0, 2'd2};
    #3;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL prio_r2 got %h want %h", rd_data[7:0], exp_v); end
    wr_call = 2'b11; wr_addr = {2'd3, 2'd1}; wr_data = {8'h3C, 8'h33};
    exp_q.push_back(8'h33); exp_q.push_back(8'h3C);
    tick(); idle(); rd_addr = {2'd3, 2'd1};
    #3;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL split_r1 got %h want %h", rd_data[7:0], exp_v); end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[15:8] !== exp_v) begin n_bad++; $display("FAIL split_r3 got %h want %h", rd_data[15:8], exp_v); end
    tick();
  endtask

  task automatic test_bypass();
    wr1(2'd0, 8'h00);
    tick();
    wr1(2'd0, 8'hC3); rd_addr = 4'h0;
`ifdef RF_RD_BYPASS_EN
    exp_q.push_back(8'hC3);
`else
    exp_q.push_back(8'h00);
`endif
    #3;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL bypass_same_cycle got %h want %h", rd_data[7:0], exp_v); end
    exp_q.push_back(8'hC3);
    tick(); idle();
    #3;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL bypass_next_cycle got %h want %h", rd_data[7:0], exp_v); end
    tick();
  endtask

  task automatic test_ckpt_restore();
    wr1(2'd1, 8'h10); ckpt_call = 1'b1;
    tick(); idle();
    n_cmp++;
    if (ckpt_valid !== 1'b1) begin n_bad++; $display("FAIL ckpt_valid_set got %b want 1", ckpt_valid); end
    wr1(2'd1, 8'h99);
    exp_q.push_back(8'h99);
    tick(); idle(); rd_addr = {2'd2, 2'd1};
    #3;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL pre_restore_r1 got %h want %h", rd_data[7:0], exp_v); end
    #1;
    @(posedge clk); #1;
    restore_call = 1'b1; wr1(2'd2, 8'h77);
    exp_q.push_back(8'h10); exp_q.push_back(8'h22);
    tick(); idle();
    #3;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL restored_r1 got %h want %h", rd_data[7:0], exp_v); end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[15:8] !== exp_v) begin n_bad++; $display("FAIL restore_drops_write_r2 got %h want %h", rd_data[15:8], exp_v); end
    n_cmp++;
    if (ckpt_valid !== 1'b0) begin n_bad++; $display("FAIL ckpt_consumed got %b want 0", ckpt_valid); end
    n_cmp++;
    if (restore_err !== 1'b0) begin n_bad++; $display("FAIL good_restore_err got %b want 0", restore_err); end
    tick();
  endtask

  task automatic test_failed_restore();
    restore_call = 1'b1; wr1(2'd3, 8'h44);
    exp_q.push_back(8'h44);
    tick(); idle(); rd_addr = {2'd0, 2'd3};
    #3;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL failed_restore_r3 got %h want %h", rd_data[7:0], exp_v); end
    n_cmp++;
    if (restore_err !== 1'b1) begin n_bad++; $display("FAIL restore_err_pulse got %b want 1", restore_err); end
    n_cmp++;
    if (ckpt_valid !== 1'b0) begin n_bad++; $display("FAIL failed_restore_ckpt_valid got %b want 0", ckpt_valid); end
    tick();
    #3;
    n_cmp++;
    if (restore_err !== 1'b0) begin n_bad++; $display("FAIL restore_err_clear got %b want 0", restore_err); end
    tick();
  endtask

  task automatic test_simultaneous();
    wr1(2'd0, 8'hAA); ckpt_call = 1'b1;
    tick(); idle();
    wr1(2'd0, 8'hBB);
    exp_q.push_back(8'hBB);
    tick(); idle(); rd_addr = 4'h0;
    #3;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL sim_pre_r0 got %h want %h", rd_data[7:0], exp_v); end
    @(posedge clk); #1;
    ckpt_call = 1'b1; restore_call = 1'b1;
    exp_q.push_back(8'hAA);
    tick(); idle();
    #3;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL sim_both_r0 got %h want %h", rd_data[7:0], exp_v); end
    n_cmp++;
    if (ckpt_valid !== 1'b1) begin n_bad++; $display("FAIL sim_both_ckpt_valid got %b want 1", ckpt_valid); end
    n_cmp++;
    if (restore_err !== 1'b0) begin n_bad++; $display("FAIL sim_both_restore_err got %b want 0", restore_err); end
    @(posedge clk); #1;
    // Dirty r0 again; the second restore must still find the original AA in the shadow.
    wr1(2'd0, 8'hBB);
    tick(); idle();
    restore_call = 1'b1;
    exp_q.push_back(8'hAA);
    tick(); idle();
    #3;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL sim_second_r0 got %h want %h", rd_data[7:0], exp_v); end
    n_cmp++;
    if (ckpt_valid !== 1'b0) begin n_bad++; $display("FAIL sim_second_ckpt_valid got %b want 0", ckpt_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] m  [4];
    logic [7:0] mn [4];
    logic [1:0] wc, wa0, wa1, ra0, ra1;
    logic [7:0] wd0, wd1;
    // Bring every register to a known value.
    wr_call = 2'b11; wr_addr = {2'd1, 2'd0}; wr_data = {8'hB1, 8'hB0};
    tick();
    wr_call = 2'b11; wr_addr = {2'd3, 2'd2}; wr_data = {8'hB3, 8'hB2};
    tick(); idle();
    m[0] = 8'hB0; m[1] = 8'hB1; m[2] = 8'hB2; m[3] = 8'hB3;
    for (int cyc = 0; cyc < 24; cyc++) begin
      wc  = 2'($urandom_range(0, 3));
      wa0 = 2'($urandom_range(0, 3));
      wa1 = (cyc % 4 == 0) ? wa0 : 2'($urandom_range(0, 3));
      wd0 = 8'($urandom_range(0, 255));
      wd1 = 8'($urandom_range(0, 255));
      ra0 = 2'($urandom_range(0, 3));
      ra1 = 2'($urandom_range(0, 3));
      for (int r = 0; r < 4; r++) mn[r] = m[r];
      if (wc[0]) mn[wa0] = wd0;
      if (wc[1]) mn[wa1] = wd1;
`ifdef RF_RD_BYPASS_EN
      exp_q.push_back(mn[ra0]); exp_q.push_back(mn[ra1]);
`else
      exp_q.push_back(m[ra0]); exp_q.push_back(m[ra1]);
`endif
      wr_call = wc; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
      rd_addr = {ra1, ra0};
      #3;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL b2b_p0 cyc %0d got %h want %h", cyc, rd_data[7:0], exp_v); end
      exp_v = exp_q.pop_front(); n_cmp++;
      if (rd_data[15:8] !== exp_v) begin n_bad++; $display("FAIL b2b_p1 cyc %0d got %h want %h", cyc, rd_data[15:8], exp_v); end
      tick();
      for (int r = 0; r < 4; r++) m[r] = mn[r];
    end
    idle();
    rd_addr = {2'd3, 2'd2};
    exp_q.push_back(m[2]); exp_q.push_back(m[3]);
    #3;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[7:0] !== exp_v) begin n_bad++; $display("FAIL b2b_final_r2 got %h want %h", rd_data[7:0], exp_v); end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (rd_data[15:8] !== exp_v) begin n_bad++; $display("FAIL b2b_final_r3 got %h want %h", rd_data[15:8], exp_v); end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_priority();
    test_bypass();
    test_ckpt_restore();
    test_failed_restore();
    test_simultaneous();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multiport_regfile_ckpt.md
# multiport_regfile_ckpt

Parametrised multi-port register file with prioritised write ports, optional same-cycle read bypass and a single-level checkpoint/restore shadow copy. It replaces the fixed one-read/one-write register files in the pipeline's architectural and rename state. The checkpoint lets branch-recovery logic snapshot the whole file in one cycle and roll it back in one cycle.

## Interface
- DW, 8: data width per register
- NREGS, 4: register count, ≥2; AW = max(1, clog2(NREGS))
- NRD, 2: read port count, ≥1
- NWR, 2: write port count, ≥1
- RESET_VALUE, 0: DW-bit value loaded into every register and every shadow entry on reset

- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- rd_addr  in  NRD*AW  read addresses, port p at [p*AW +: AW]
- rd_data  out  NRD*DW  read data, port p at [p*DW +: DW]
- wr_call  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*DW  write data
- ckpt_call  in  1  capture checkpoint this cycle
- restore_call  in  1  roll back to the checkpoint this cycle
- ckpt_valid  out  1  a checkpoint is held
- restore_err  out  1  one-cycle pulse: previous cycle's restore had no valid checkpoint

## Operation
- State: regs[NREGS], shadow[NREGS], ckpt_valid flag, restore_err flag.
- Write merge: next[r] starts as regs[r]. Ports apply in ascending index order. The highest-index port with wr_call=1 and wr_addr=r wins.
- Addresses ≥ NREGS: the write is ignored and reads return 0.
- Read: rd_data[p] = regs[rd_addr[p]] (see Configuration for bypass).
- Checkpoint: on ckpt_call, shadow[r] <= next[r] for all r, so it includes this cycle's writes. ckpt_valid <= 1.
- Restore with ckpt_valid=1: regs[r] <= shadow[r] for all r, discarding this cycle's writes. ckpt_valid <= 0.
- Restore with ckpt_valid=0: the restore is ignored, writes commit normally, and restore_err <= 1.
- restore_err <= 0 on every cycle without a failed restore.
- ckpt_call and restore_call together with ckpt_valid=1:
  - restore wins for regs: regs <= old shadow.
  - shadow <= old shadow, so the contents are unchanged.
  - ckpt_valid stays 1. The checkpoint is re-armed, not consumed.
- ckpt_call and restore_call together with ckpt_valid=0:
  - restore_err <= 1.
  - The checkpoint is taken from next.
  - ckpt_valid <= 1.
- Otherwise regs[r] <= next[r].

## Timing
- Reset (async assert): regs and shadow = RESET_VALUE, ckpt_valid=0, restore_err=0.
  - rd_data reflects RESET_VALUE combinationally during reset.
  - Inputs are ignored while reset is high. Release is synchronous to clk by the system.
- Read latency: 0 cycles, combinational from rd_addr and state.
- Write latency: 1 cycle. The data is visible on reads the cycle after wr_call.
- Checkpoint and restore each take effect at the capturing edge. Restored values are readable the next cycle.
- restore_err is asserted for exactly the one cycle following the failed restore edge.
- No handshake or backpressure: every call is accepted every cycle.

## Configuration
- RF_RD_BYPASS_EN defined: rd_data[p] returns next[rd_addr[p]], the post-write-merge value including the highest-priority same-cycle write.
  - Checkpoint/restore are not bypassed: a same-cycle restore is not visible until the next cycle.
- RF_RD_BYPASS_EN undefined: rd_data[p] returns registered regs only. There is no combinational path from wr_* to rd_data.

## Test plan
- Reset with RESET_VALUE=8'h5A: assert reset mid-cycle without a clock edge -> all rd_data=8'h5A, ckpt_valid=0, restore_err=0 immediately.
- Write priority: wr_call=2'b11, both addr=2, data0=8'h11, data1=8'h22 -> next cycle rd_addr=2 returns 8'h22. Separate addrs 1 and 3 -> both written.
- Bypass: write addr 0 = 8'hC3 while rd_addr=0 -> rd_data=8'hC3 same cycle with RF_RD_BYPASS_EN, old value 8'h00 without; 8'hC3 next cycle in both builds.
- Checkpoint/restore:
  - Write r1=8'h10 together with ckpt_call -> ckpt_valid=1.
  - Write r1=8'h99 -> r1 reads 8'h99.
  - restore_call plus a write r2=8'h77 -> next cycle r1=8'h10, r2 unchanged, ckpt_valid=0.
- Failed restore: restore_call with ckpt_valid=0 and write r3=8'h44 -> r3=8'h44, restore_err=1 for exactly one cycle, then 0.
- Simultaneous: with a checkpoint held (r0=8'hAA), write r0=8'hBB, then ckpt_call+restore_call together -> r0=8'hAA, ckpt_valid stays 1. A second restore -> r0=8'hAA, ckpt_valid=0.
